// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Main sequencing controller of the multi-cycle RISC core. Steps
//            each instruction through fetch / decode / execute / memory /
//            write-back, stalls on the memory ready handshake, sequences the
//            stack operations (CALL/RET/PUSH/POP) and traps illegal opcodes
//            and memory timeouts into a sticky FAULT state.
// Ports    : clk, reset (sync, active-high)
//            opcode     - instruction opcode from IR
//            alu_zero   - ALU result == 0 (same cycle)
//            alu_neg    - ALU result sign bit
//            mem_ready  - memory completes the current access this cycle
//            pc_write/pc_src, ir_write, reg_write/wb_sel, alu_src_b, alu_op,
//            mem_read/mem_write/mem_addr_sel/mem_data_sel, sp_write/sp_dir
//                       - datapath control
//            state      - current state (debug), fault - sticky trap flag
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int MAX_WAIT = 16,
  parameter int OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                alu_src_b,
  output logic [1:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_addr_sel,
  output logic                mem_data_sel,
  output logic                sp_write,
  output logic                sp_dir,
  output logic [3:0]          state,
  output logic                fault
);

  // Wait counter only ever holds 0 .. MAX_WAIT-1.
  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LWPOI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BGT   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_PUSH  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_POP   = OPCODE_W'(16);

  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_NONE = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_WB_POI  = 4'd9,
    S_BRANCH  = 4'd10,
    S_PUSH    = 4'd11,
    S_POP_ADJ = 4'd12,
    S_POP_RD  = 4'd13,
    S_FAULT   = 4'd14
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          w_wait_limit;
  logic          w_taken;

  // ALU select for the arithmetic opcodes (register and immediate forms).
  function automatic logic [1:0] alu_map(input logic [OPCODE_W-1:0] op);
    if (op == OP_AND || op == OP_ANDI)      alu_map = ALU_AND;
    else if (op == OP_ADD || op == OP_ADDI) alu_map = ALU_ADD;
    else if (op == OP_SUB)                  alu_map = ALU_SUB;
    else                                    alu_map = ALU_NONE;
  endfunction

  function automatic logic is_wait_state(input state_e s);
    is_wait_state = (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR) ||
                    (s == S_PUSH)  || (s == S_POP_RD);
  endfunction

  assign w_wait_limit = (wait_cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    case (opcode)
      OP_BGT:  w_taken = !alu_zero && !alu_neg;
      OP_BLT:  w_taken = alu_neg;
      OP_BEQ:  w_taken = alu_zero;
      OP_BNE:  w_taken = !alu_zero;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_NONE;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 2'd0;
    mem_data_sel = 1'b0;
    sp_write     = 1'b0;
    sp_dir       = 1'b0;
    fault        = 1'b0;

    // Reset overrides the decoded outputs so an in-flight access is aborted
    // without any architectural write in the reset cycle.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (w_wait_limit) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          if (opcode <= OP_SUB)       state_d = S_EXEC_R;
          else if (opcode <= OP_ADDI) state_d = S_EXEC_I;
          else if (opcode <= OP_SW)   state_d = S_ADDR;
          else if (opcode <= OP_BNE)  state_d = S_BRANCH;
          else if (opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_FETCH;
          end
          else if (opcode == OP_CALL || opcode == OP_PUSH) state_d = S_PUSH;
          else if (opcode == OP_RET  || opcode == OP_POP)  state_d = S_POP_ADJ;
          else state_d = S_FAULT;
        end
        S_EXEC_R: begin
          alu_op  = alu_map(opcode);
          state_d = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_b = 1'b1;
          alu_op    = alu_map(opcode);
          state_d   = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_ADDR: begin
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
          state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read     = 1'b1;
          mem_addr_sel = 2'd1;
          if (mem_ready)         state_d = S_WB_MEM;
          else if (w_wait_limit) state_d = S_FAULT;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 2'd1;
          state_d   = (opcode == OP_LWPOI) ? S_WB_POI : S_FETCH;
        end
        S_WB_POI: begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          state_d   = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write    = 1'b1;
          mem_addr_sel = 2'd1;
          if (mem_ready)         state_d = S_FETCH;
          else if (w_wait_limit) state_d = S_FAULT;
        end
        S_BRANCH: begin
          alu_op = ALU_SUB;
          if (w_taken) begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
          end
          state_d = S_FETCH;
        end
        S_PUSH: begin
          // CALL pushes the return address; PUSH pushes register B.
          mem_write    = 1'b1;
          mem_addr_sel = 2'd2;
          mem_data_sel = (opcode == OP_CALL);
          if (mem_ready) begin
            sp_write = 1'b1;
            if (opcode == OP_CALL) begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            state_d = S_FETCH;
          end else if (w_wait_limit) begin
            state_d = S_FAULT;
          end
        end
        S_POP_ADJ: begin
          sp_write = 1'b1;
          sp_dir   = 1'b1;
          state_d  = S_POP_RD;
        end
        S_POP_RD: begin
          mem_read     = 1'b1;
          mem_addr_sel = 2'd2;
          if (mem_ready) begin
            if (opcode == OP_RET) begin
              pc_write = 1'b1;
              pc_src   = 2'd3;
            end else begin
              reg_write = 1'b1;
              wb_sel    = 2'd1;
            end
            state_d = S_FETCH;
          end else if (w_wait_limit) begin
            state_d = S_FAULT;
          end
        end
        S_FAULT: begin
          fault   = 1'b1;
          state_d = S_FAULT;
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

  // The counter only survives while a wait state stalls in place; any state
  // change (including entry into a wait state) starts it again from zero.
  always_comb begin
    if (is_wait_state(state_q) && (state_d == state_q)) wait_cnt_d = wait_cnt_q + CW'(1);
    else                                                 wait_cnt_d = '0;
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Self-checking bench for multicycle_control_fsm. A table of
//            per-cycle {inputs, expected outputs} records walks several
//            instructions; hand-written sequences cover the wait-limit
//            timeout, ready-at-limit completion and illegal opcode trap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       alu_zero, alu_neg, mem_ready;
  logic       pc_write, ir_write, reg_write, alu_src_b, mem_read, mem_write;
  logic       mem_data_sel, sp_write, sp_dir, fault;
  logic [1:0] pc_src, wb_sel, alu_op, mem_addr_sel;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MAX_WAIT(16), .OPCODE_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .mem_data_sel(mem_data_sel), .sp_write(sp_write), .sp_dir(sp_dir),
    .state(state), .fault(fault)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic [1:0] wbs;
    logic       asb;
    logic [1:0] aop;
    logic       mr;
    logic       mw;
    logic [1:0] mas;
    logic       mds;
    logic       spw;
    logic       spd;
    logic       flt;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       n;
    logic       rdy;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic out_t E(int st, int pcw, int pcs, int irw, int rw, int wbs,
                             int asb, int aop, int mr, int mw, int mas, int mds,
                             int spw, int spd, int flt);
    out_t o;
    o.st = 4'(st);  o.pcw = 1'(pcw); o.pcs = 2'(pcs); o.irw = 1'(irw);
    o.rw = 1'(rw);  o.wbs = 2'(wbs); o.asb = 1'(asb); o.aop = 2'(aop);
    o.mr = 1'(mr);  o.mw  = 1'(mw);  o.mas = 2'(mas); o.mds = 1'(mds);
    o.spw = 1'(spw); o.spd = 1'(spd); o.flt = 1'(flt);
    return o;
  endfunction

  function automatic out_t IDLE(int st);
    return E(st, 0,0,0,0,0,0,3,0,0,0,0,0,0,0);
  endfunction

  // FETCH completing (ready=1) and FETCH stalling (ready=0).
  function automatic out_t FOK();
    return E(0, 1,0,1,0,0,0,3,1,0,0,0,0,0,0);
  endfunction
  function automatic out_t FWAIT();
    return E(0, 0,0,0,0,0,0,3,1,0,0,0,0,0,0);
  endfunction

  task automatic add(input logic rst, input int op, input logic z, input logic n,
                     input logic rdy, input out_t exp);
    vec_t v;
    v.rst = rst; v.op = 6'(op); v.z = z; v.n = n; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Fetch and a plain (idle-output) decode of one instruction.
  task automatic fd(input int op);
    add(0, op, 0, 0, 1, FOK());
    add(0, op, 0, 0, 1, IDLE(1));
  endtask

  // One clock: drive inputs, queue the expectation, compare mid-cycle.
  task automatic step(input string tag, input int idx, input logic rst,
                      input int op, input logic z, input logic n,
                      input logic rdy, input out_t exp);
    out_t act, e;
    reset = rst; opcode = 6'(op); alu_zero = z; alu_neg = n; mem_ready = rdy;
    exp_q.push_back(exp);
    @(negedge clk);
    act = '{state, pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_b,
            alu_op, mem_read, mem_write, mem_addr_sel, mem_data_sel, sp_write,
            sp_dir, fault};
    e = exp_q.pop_front();
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h (state %0d) expected %h (state %0d)",
               tag, idx, act, act.st, e, e.st);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; opcode = '0; alu_zero = 0; alu_neg = 0; mem_ready = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- table ----------------
    add(1, 1, 0, 0, 1, IDLE(0));                               // reset row
    // ADD: 0,1,2,7
    fd(1);
    add(0, 1, 0, 0, 1, E(2, 0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    add(0, 1, 0, 0, 1, E(7, 0,0,0,1,0,0,3,0,0,0,0,0,0,0));
    // LWPOI with 3 stall cycles in MEM_RD
    fd(6);
    add(0, 6, 0, 0, 1, E(4, 0,0,0,0,0,1,1,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      add(0, 6, 0, 0, 0, E(5, 0,0,0,0,0,0,3,1,0,1,0,0,0,0));
    add(0, 6, 0, 0, 1, E(5, 0,0,0,0,0,0,3,1,0,1,0,0,0,0));
    add(0, 6, 0, 0, 1, E(8, 0,0,0,1,1,0,3,0,0,0,0,0,0,0));
    add(0, 6, 0, 0, 1, E(9, 0,0,0,1,2,0,3,0,0,0,0,0,0,0));
    // BEQ taken, BEQ not taken, BGT with neg (not taken), BLT with neg (taken)
    fd(10); add(0, 10, 1, 0, 1, E(10, 1,1,0,0,0,0,2,0,0,0,0,0,0,0));
    fd(10); add(0, 10, 0, 0, 1, E(10, 0,0,0,0,0,0,2,0,0,0,0,0,0,0));
    fd(8);  add(0,  8, 0, 1, 1, E(10, 0,0,0,0,0,0,2,0,0,0,0,0,0,0));
    fd(9);  add(0,  9, 0, 1, 1, E(10, 1,1,0,0,0,0,2,0,0,0,0,0,0,0));
    // CALL then RET
    fd(13); add(0, 13, 0, 0, 1, E(11, 1,2,0,0,0,0,3,0,1,2,1,1,0,0));
    fd(14); add(0, 14, 0, 0, 1, E(12, 0,0,0,0,0,0,3,0,0,0,0,1,1,0));
    add(0, 14, 0, 0, 1, E(13, 1,3,0,0,0,0,3,1,0,2,0,0,0,0));
    // SW, reset asserted in MEM_WR with ready high: nothing commits
    fd(7);  add(0, 7, 0, 0, 1, E(4, 0,0,0,0,0,1,1,0,0,0,0,0,0,0));
    add(1, 7, 0, 0, 1, IDLE(6));
    // PUSH and POP
    fd(15); add(0, 15, 0, 0, 1, E(11, 0,0,0,0,0,0,3,0,1,2,0,1,0,0));
    fd(16); add(0, 16, 0, 0, 1, E(12, 0,0,0,0,0,0,3,0,0,0,0,1,1,0));
    add(0, 16, 0, 0, 1, E(13, 0,0,0,1,1,0,3,1,0,2,0,0,0,0));
    // JMP commits in DECODE
    add(0, 12, 0, 0, 1, FOK());
    add(0, 12, 0, 0, 1, E(1, 1,2,0,0,0,0,3,0,0,0,0,0,0,0));
    // AND, ANDI, SUB alu_op mapping
    fd(0); add(0, 0, 0, 0, 1, E(2, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, 0, 0, 0, 1, E(7, 0,0,0,1,0,0,3,0,0,0,0,0,0,0));
    fd(3); add(0, 3, 0, 0, 1, E(3, 0,0,0,0,0,1,0,0,0,0,0,0,0,0));
    add(0, 3, 0, 0, 1, E(7, 0,0,0,1,0,0,3,0,0,0,0,0,0,0));
    fd(2); add(0, 2, 0, 0, 1, E(2, 0,0,0,0,0,0,2,0,0,0,0,0,0,0));
    add(0, 2, 0, 0, 1, E(7, 0,0,0,1,0,0,3,0,0,0,0,0,0,0));
    add(0, 2, 0, 0, 1, FOK());

    do_reset();
    foreach (tbl[i])
      step("tbl", i, tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].n, tbl[i].rdy, tbl[i].exp);

    // ---------------- FETCH timeout: 16 stalled cycles then FAULT ----------------
    do_reset();
    for (int i = 0; i < 16; i++) step("tmo", i, 0, 1, 0, 0, 0, FWAIT());
    step("tmo_fault", 0, 0, 1, 0, 0, 1, E(14, 0,0,0,0,0,0,3,0,0,0,0,0,0,1));
    step("tmo_fault", 1, 0, 1, 0, 0, 1, E(14, 0,0,0,0,0,0,3,0,0,0,0,0,0,1));
    step("tmo_rst", 0, 1, 1, 0, 0, 1, IDLE(14));
    step("tmo_clr", 0, 0, 1, 0, 0, 1, FOK());

    // ---------------- ready on the limit cycle completes normally ----------------
    do_reset();
    for (int i = 0; i < 15; i++) step("lim", i, 0, 1, 0, 0, 0, FWAIT());
    step("lim_ok", 0, 0, 1, 0, 0, 1, FOK());
    step("lim_dec", 0, 0, 1, 0, 0, 1, IDLE(1));

    // ---------------- illegal opcode traps from DECODE ----------------
    do_reset();
    step("ill", 0, 0, 20, 0, 0, 1, FOK());
    step("ill", 1, 0, 20, 0, 0, 1, IDLE(1));
    step("ill", 2, 0, 20, 0, 0, 1, E(14, 0,0,0,0,0,0,3,0,0,0,0,0,0,1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
